// File: rtl/riscv_pkg.sv
// riscv_pkg: types and constants shared by the fetch stage, the program
// counter and their benches.
//   fetch_state_t : instruction fetch FSM states
//   INSTR_W       : instruction width
//   PC_INC        : sequential PC step in bytes
//   RESET_PC      : program_counter value after reset
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        ERR
    } fetch_state_t;

    localparam int          INSTR_W  = 32;
    localparam int          PC_INC   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the non-pipelined core. It fetches the word
// at pc_in over a req/gnt/rvalid memory port, holds it for decode under a
// valid/ready handshake, and steers program_counter with pc_next/pc_en
// (sequential +4 or an execute redirect).
//
// Ports
//   clk, rst                  core clock, synchronous active-low reset
//   pc_in                     current PC from program_counter
//   pc_next, pc_en            next PC and one-cycle load strobe
//   imem_req/addr/gnt         memory request channel
//   imem_rvalid/rdata         memory response channel
//   instr_valid/instr/instr_pc/instr_ready   decode handshake
//   redirect_valid/redirect_pc               branch/jump redirect
//   fetch_err                 level, PC is not word aligned
//
// state | meaning
// IDLE  | one cycle after reset release, no activity
// REQ   | request issued at pc_in, waiting for grant
// WAIT  | granted, waiting for the response
// HOLD  | instruction presented to decode
// DRAIN | response of an abandoned request still due, discard it
// ERR   | misaligned PC, parked until redirect
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int Reg_size = 32,
    parameter int INSTR_W  = riscv_pkg::INSTR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Reg_size-1:0] pc_in,
    output logic [Reg_size-1:0] pc_next,
    output logic                pc_en,
    output logic                imem_req,
    output logic [Reg_size-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [Reg_size-1:0] instr_pc,
    input  logic                instr_ready,
    input  logic                redirect_valid,
    input  logic [Reg_size-1:0] redirect_pc,
    output logic                fetch_err
);

    fetch_state_t state, state_nxt;
    logic         capture;
    logic         pc_aligned;

    assign pc_aligned  = (pc_in[1:0] == 2'b00);
    assign instr_valid = (state == HOLD);
    assign fetch_err   = (state == ERR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = '0;
        pc_en     = 1'b0;
        pc_next   = '0;
        capture   = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;

            REQ: begin
                imem_addr = pc_in;
                imem_req  = pc_aligned;
                // A redirect withdraws an ungranted request; a granted one
                // still owes a response that must be drained.
                if (redirect_valid)
                    state_nxt = (pc_aligned && imem_gnt) ? DRAIN : REQ;
                else if (!pc_aligned)
                    state_nxt = ERR;
                else if (imem_gnt)
                    state_nxt = WAIT;
            end

            WAIT: begin
                if (redirect_valid)
                    state_nxt = imem_rvalid ? REQ : DRAIN;
                else if (imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (redirect_valid)
                    state_nxt = REQ;
                else if (instr_ready) begin
                    pc_en     = 1'b1;
                    pc_next   = pc_in + Reg_size'(PC_INC);
                    state_nxt = REQ;
                end
            end

            // The owed response ends the drain even if a redirect arrives in
            // the same cycle; the redirect itself only moves the PC.
            DRAIN: begin
                if (imem_rvalid)
                    state_nxt = REQ;
            end

            ERR: begin
                if (redirect_valid)
                    state_nxt = REQ;
            end

            default: state_nxt = IDLE;
        endcase

        if (redirect_valid && (state != IDLE)) begin
            pc_en   = 1'b1;
            pc_next = redirect_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    always #5 clk = ~clk;

    instr_fetch #(.Reg_size(32), .INSTR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_next        (pc_next),
        .pc_en          (pc_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17 ^ {a[15:0], a[31:16]};
    endfunction

    // program_counter stand-in
    always @(posedge clk) begin
        if (!rst)       pc_in <= RESET_PC;
        else if (pc_en) pc_in <= pc_next;
    end

    // Behavioural instruction memory: grant after gnt_dly waiting cycles,
    // response rv_dly cycles after the grant (rv_dly >= 1).
    int          gnt_dly = 0;
    int          rv_dly  = 1;
    int          req_cnt = 0;
    int          rv_cnt  = 0;
    bit          pending = 1'b0;
    logic [31:0] pend_addr = '0;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            pending = 1'b0;
            req_cnt = 0;
            rv_cnt  = 0;
        end else begin
            if (imem_rvalid)  pending = 1'b0;
            else if (pending) rv_cnt++;
            if (imem_req && imem_gnt) begin
                pending   = 1'b1;
                pend_addr = imem_addr;
                rv_cnt    = 0;
                req_cnt   = 0;
            end else if (imem_req) req_cnt++;
            else                   req_cnt = 0;
        end
        #1;
        imem_gnt    = rst && imem_req && !pending && (req_cnt >= gnt_dly);
        imem_rvalid = rst && pending && (rv_cnt >= rv_dly - 1);
        imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    end

    // Scoreboard
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   hs_count    = 0;
    int   cyc         = 0;
    int   last_hs_cyc = -1;
    bit   tput_chk    = 1'b0;
    bit   dirty       = 1'b1;
    int   gnt_cnt     = 0;

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem_word(pc);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s at %0t", name, detail, $time);
        end
    endtask

    exp_t        m_cur;
    logic [31:0] m_nxt;
    bit          m_hs;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            exp_q.push_back(mk(RESET_PC));
            dirty       = 1'b1;
            gnt_cnt     = 0;
            last_hs_cyc = -1;
        end else begin
            cyc++;
            m_cur = (exp_q.size() > 0) ? exp_q[0] : '0;
            if (imem_req)
                chk("imem_addr", imem_addr, m_cur.pc);
            if (fetch_err)
                chk_b(m_cur.pc[1:0] != 2'b00 && !imem_req, "fetch_err",
                      $sformatf("err with pc %h req %b, required misaligned pc and no req",
                                m_cur.pc, imem_req));
            if (instr_valid) begin
                chk("instr", instr, m_cur.data);
                chk("instr_pc", instr_pc, m_cur.pc);
                chk("req_in_hold", {31'b0, imem_req}, 32'd0);
            end
            m_hs = instr_valid && instr_ready;
            chk("pc_en", {31'b0, pc_en}, {31'b0, (redirect_valid || m_hs)});
            m_nxt = redirect_valid ? redirect_pc : m_cur.pc + 32'd4;
            if (pc_en)
                chk("pc_next", pc_next, m_nxt);
            if (imem_req && imem_gnt)
                gnt_cnt++;
            if (m_hs) begin
                if (!dirty)
                    chk("fetch_count", gnt_cnt, 32'd1);
                if (tput_chk && last_hs_cyc >= 0)
                    chk("interval", cyc - last_hs_cyc, 32'd3);
                last_hs_cyc = cyc;
                hs_count++;
                void'(exp_q.pop_front());
                dirty   = 1'b0;
                gnt_cnt = 0;
                if (!redirect_valid)
                    exp_q.push_back(mk(m_nxt));
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(mk(redirect_pc));
                dirty       = 1'b1;
                gnt_cnt     = 0;
                last_hs_cyc = -1;
            end
        end
    end

    // Driver
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_hs(input int n, input int limit);
        int tgt;
        int k;
        tgt = hs_count + n;
        k   = 0;
        while (hs_count < tgt && k < limit) begin
            tick();
            k++;
        end
        chk_b(hs_count >= tgt, "hs_timeout",
              $sformatf("handshakes %0d required %0d", hs_count, tgt));
    endtask

    task automatic wait_grant(input int limit);
        int k;
        k = 0;
        while (!(imem_req && imem_gnt) && k < limit) begin
            tick();
            k++;
        end
        chk_b(imem_req && imem_gnt, "grant_timeout", "no grant within budget");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"},         {31'b0, imem_req},    32'd0);
        chk({tag, "_pc_en"},       {31'b0, pc_en},       32'd0);
        chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_fetch_err"},   {31'b0, fetch_err},   32'd0);
        chk({tag, "_instr"},       instr,                32'd0);
        chk({tag, "_instr_pc"},    instr_pc,             32'd0);
        chk({tag, "_pc_next"},     pc_next,              32'd0);
        chk({tag, "_imem_addr"},   imem_addr,            32'd0);
    endtask

    initial begin
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        int          k;

        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) tick();
        check_zero("reset");

        // 1: zero-wait memory, decode always ready
        gnt_dly     = 0;
        rv_dly      = 1;
        instr_ready = 1'b1;
        tput_chk    = 1'b1;
        rst         = 1'b1;
        wait_hs(4, 40);
        tput_chk = 1'b0;
        chk("t1_pc_in", pc_in, 32'd16);

        // 2: slow grant and response
        gnt_dly = 2;
        rv_dly  = 3;
        wait_hs(3, 60);

        // 3: decode stalls in HOLD
        gnt_dly     = 0;
        rv_dly      = 1;
        instr_ready = 1'b0;
        k = 0;
        while (!instr_valid && k < 40) begin
            tick();
            k++;
        end
        chk("t3_valid", {31'b0, instr_valid}, 32'd1);
        held_instr = instr;
        held_pc    = instr_pc;
        repeat (5) tick();
        chk("t3_instr_stable", instr, held_instr);
        chk("t3_pc_stable", instr_pc, held_pc);
        chk("t3_no_pc_en", {31'b0, pc_en}, 32'd0);
        instr_ready = 1'b1;
        wait_hs(1, 5);

        // 4: redirect while a response is outstanding
        rv_dly = 4;
        wait_grant(20);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        k = 0;
        while (!imem_req && k < 20) begin
            tick();
            k++;
        end
        chk("t4_addr", imem_addr, 32'h100);
        wait_hs(1, 20);

        // 5: misaligned redirect, then recovery
        rv_dly = 1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        chk("t5_err", {31'b0, fetch_err}, 32'd1);
        chk("t5_no_req", {31'b0, imem_req}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("t5_err_clear", {31'b0, fetch_err}, 32'd0);
        wait_hs(1, 20);
        chk("t5_pc_in", pc_in, 32'h204);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_hs(1, 20);
        chk("wrap_pc_in", pc_in, 32'h0);
        wait_hs(1, 20);

        // 6: reset while waiting for a response
        rv_dly = 3;
        wait_grant(20);
        tick();
        rst = 1'b0;
        tick();
        check_zero("mid_reset");
        rst = 1'b1;
        tick();
        chk("idle_req", {31'b0, imem_req}, 32'd1);
        chk("idle_addr", imem_addr, RESET_PC);
        wait_hs(2, 30);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                gnt_dly = $urandom_range(0, 3);
                rv_dly  = $urandom_range(1, 4);
            end
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 4) == 0)
                redirect_pc = {20'b0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
            else
                redirect_pc = {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        wait_hs(2, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
